lcd_clk_ctrl: RTL
=================

# lcd_clk_ctrl

Pixel-clock controller for the LCD path: it turns the panel ID (from the LCD ID read-back logic) into a divide ratio off clk_50m. It sequences a clean switch-over: quiesce, reload the divider, then run. Outputs are a registered divided clock, a one-cycle pixel-clock enable, and a `locked` flag that gates the LCD timing and driver logic downstream.

## Interface
Parameters:
- QUIESCE_CYC, default 16: clocks for which outputs are held idle between accepting an ID and running. Legal range is 2..255.

Ports:
- clk_50m, input, 1: system clock, 50 MHz. This is the only clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- lcd_id, input, 16: panel ID. Sampled only when id_valid is high.
- id_valid, input, 1: one-cycle strobe marking lcd_id as valid.
- lcd_pclk, output, 1: registered divided pixel clock. Duty is 50% for ratios of 2 or more; held 0 for ratio 1.
- pclk_en, output, 1: high for one clk_50m cycle per pixel period. Constantly high for ratio 1.
- rate_sel, output, 2: active ratio. 0 means /1, 1 means /2, 2 means /4. Value 3 is never driven.
- locked, output, 1: divider running with a stable ratio.

## Operation
ID to ratio mapping, decoded from the registered ID:
- 16'h9341 maps to /4 (rate_sel 2).
- 16'h5310 maps to /2 (rate_sel 1).
- 16'h5510, 16'h1963 and any other value map to /1 (rate_sel 0).

Internal state:
- id_reg (16 bit).
- qcnt: width clog2(QUIESCE_CYC), minimum 1.
- phase counter pcnt (2 bit), counting modulo the ratio.

State machine (all transitions on the clk_50m rising edge):
- WAIT_ID (reset state):
  - locked=0, pclk_en=0, lcd_pclk=0.
  - On id_valid: load id_reg=lcd_id and qcnt=QUIESCE_CYC-1, then go to QUIESCE.
- QUIESCE:
  - Outputs are the same as WAIT_ID. rate_sel already reflects the new id_reg.
  - qcnt decrements by 1 each clock.
  - At qcnt==0: go to RUN with pcnt=0.
  - On id_valid: reload id_reg and qcnt (restart the count), whatever the ID value.
- RUN:
  - locked=1.
  - pcnt advances modulo the ratio.
  - pclk_en=1 when pcnt==0.
  - lcd_pclk=1 when pcnt < ratio/2 (ratio of 2 or more).
  - id_valid with lcd_id != id_reg: load id_reg and qcnt, go to QUIESCE. All outputs go low on that same edge.
  - id_valid with lcd_id == id_reg: ignored. The phase is not disturbed.

Output rules:
- All outputs are registers, updated on the same edge as the state, with no combinational path from the inputs.
- rate_sel is registered from id_reg and changes only on id_valid acceptance.

Reset:
- rst_n low at any clock edge, mid-quiesce or mid-run included, forces WAIT_ID.
- Reset values: id_reg=0, qcnt=0, pcnt=0, locked=0, pclk_en=0, lcd_pclk=0, rate_sel=0.

## Timing
- Accepting edge E0 is the edge that samples id_valid=1.
  - locked, pclk_en and (for ratios of 2 or more) lcd_pclk are first high after edge E0+QUIESCE_CYC.
  - rate_sel updates after E0.
- Output patterns in RUN, starting from the first locked cycle:
  - /4: lcd_pclk 1,1,0,0 and pclk_en 1,0,0,0, repeating.
  - /2: lcd_pclk 1,0 and pclk_en 1,0, repeating.
  - /1: lcd_pclk 0 and pclk_en 1 every cycle.
- Change of ID in RUN: locked falls after the accepting edge. lcd_pclk may be truncated at that point, but is never high for longer than ratio/2 cycles.
- id_valid on the same edge as qcnt==0 in QUIESCE: the reload wins and the machine stays in QUIESCE for the full QUIESCE_CYC.
- No output toggles while locked=0.

## Test plan
- Reset, then id_valid with 16'h9341:
  - rate_sel=2 and locked=1 exactly 16 clocks after the accepting edge.
  - lcd_pclk is 1100 periodic; pclk_en pulses every 4th clock.
- ID 16'h5310:
  - rate_sel=1; lcd_pclk toggles every clock; pclk_en on alternate clocks.
- ID 16'h1963, then 16'hABCD:
  - Both give rate_sel=0, pclk_en constantly 1, lcd_pclk=0.
  - The second ID forces a 16-cycle drop of locked because the ID changed.
- In RUN at /4, id_valid repeats 16'h9341:
  - No change to locked or phase. Compare cycle-by-cycle against an undisturbed reference run.
- In QUIESCE:
  - id_valid with 16'h5310 at qcnt==5 restarts the count; locked rises 16 clocks after the second strobe.
  - Check the simultaneous case at qcnt==0.
- rst_n pulsed low for 1 cycle, mid-RUN and separately mid-QUIESCE:
  - All outputs are 0 after that edge and the machine is in WAIT_ID.
  - No re-lock until a new id_valid.

Source files
------------

// File: rtl/lcd_clk_ctrl.sv
// Pixel-clock controller: maps the panel ID to a /1, /2 or /4 ratio off clk_50m and sequences quiesce -> reload -> run.
// Latency: outputs first active QUIESCE_CYC clocks after the edge that accepts an ID; all outputs are registered.
// Backpressure: none; id_valid is a one-cycle strobe that is always taken (an unchanged ID while running is ignored).
module lcd_clk_ctrl #(
  parameter int unsigned QUIESCE_CYC = 16
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic [15:0] lcd_id,
  input  logic        id_valid,
  output logic        lcd_pclk,
  output logic        pclk_en,
  output logic [1:0]  rate_sel,
  output logic        locked
);

  // Quiesce counter must hold QUIESCE_CYC-1; never narrower than one bit.
  localparam int unsigned    QW    = (QUIESCE_CYC > 2) ? $clog2(QUIESCE_CYC) : 1;
  localparam logic [QW-1:0]  QLOAD = QW'(QUIESCE_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_ID = 2'd0,
    QUIESCE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     id_reg_q, id_reg_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      pcnt_q, pcnt_d;
  logic [1:0]      rate_sel_q, rate_sel_d;
  logic            locked_q, locked_d;
  logic            pclk_en_q, pclk_en_d;
  logic            lcd_pclk_q, lcd_pclk_d;
  logic            accept;
  logic            run_out;

  // Known panels get a slower pixel clock; everything else runs at the full 50 MHz.
  function automatic logic [1:0] decode_rate(input logic [15:0] id);
    logic [1:0] r;
    case (id)
      16'h9341: r = 2'd2;
      16'h5310: r = 2'd1;
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

  // State, ID, counters and all outputs update together on the rising edge.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q    <= WAIT_ID;
      id_reg_q   <= '0;
      qcnt_q     <= '0;
      pcnt_q     <= '0;
      rate_sel_q <= '0;
      locked_q   <= 1'b0;
      pclk_en_q  <= 1'b0;
      lcd_pclk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_reg_q   <= id_reg_d;
      qcnt_q     <= qcnt_d;
      pcnt_q     <= pcnt_d;
      rate_sel_q <= rate_sel_d;
      locked_q   <= locked_d;
      pclk_en_q  <= pclk_en_d;
      lcd_pclk_q <= lcd_pclk_d;
    end
  end

  // Next state plus next register values of the outputs, computed from the phase the next cycle will be in.
  always_comb begin
    state_d    = state_q;
    id_reg_d   = id_reg_q;
    qcnt_d     = qcnt_q;
    pcnt_d     = pcnt_q;
    locked_d   = 1'b0;
    pclk_en_d  = 1'b0;
    lcd_pclk_d = 1'b0;
    accept     = 1'b0;
    run_out    = 1'b0;

    case (state_q)
      WAIT_ID: begin
        if (id_valid) begin
          accept  = 1'b1;
          state_d = QUIESCE;
        end
      end
      QUIESCE: begin
        // A strobe restarts the quiet period even on the final count.
        if (id_valid) begin
          accept = 1'b1;
        end else if (qcnt_q == '0) begin
          state_d = RUN;
          pcnt_d  = 2'd0;
          run_out = 1'b1;
        end else begin
          qcnt_d = qcnt_q - 1'b1;
        end
      end
      RUN: begin
        if (id_valid && (lcd_id != id_reg_q)) begin
          accept  = 1'b1;
          state_d = QUIESCE;
        end else begin
          case (rate_sel_q)
            2'd2:    pcnt_d = pcnt_q + 2'd1;
            2'd1:    pcnt_d = {1'b0, ~pcnt_q[0]};
            default: pcnt_d = 2'd0;
          endcase
          run_out = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_ID;
      end
    endcase

    if (accept) begin
      id_reg_d = lcd_id;
      qcnt_d   = QLOAD;
    end

    if (run_out) begin
      locked_d  = 1'b1;
      pclk_en_d = (pcnt_d == 2'd0);
      case (rate_sel_q)
        2'd2:    lcd_pclk_d = ~pcnt_d[1];
        2'd1:    lcd_pclk_d = (pcnt_d == 2'd0);
        default: lcd_pclk_d = 1'b0;
      endcase
    end
  end

  // rate_sel follows the ID register, so it only moves when an ID is accepted.
  always_comb begin
    rate_sel_d = decode_rate(id_reg_d);
  end

  assign lcd_pclk = lcd_pclk_q;
  assign pclk_en  = pclk_en_q;
  assign rate_sel = rate_sel_q;
  assign locked   = locked_q;

endmodule
